// File: rtl/timer_set_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_set_pkg
// Purpose  : Shared field selects, BCD limits and set_time layout for the
//            timer-set datapath.
// Revision : 1.0 - initial release
// ============================================================================
package timer_set_pkg;

    localparam logic [1:0] FIELD_HOUR  = 2'd0;
    localparam logic [1:0] FIELD_MIN   = 2'd1;

    localparam logic [7:0] LIMIT_HOUR  = 8'h23;
    localparam logic [7:0] LIMIT_MIN   = 8'h59;

    localparam logic [3:0] BCD_MAX     = 4'd9;

    localparam int         SET_FIELD_W = 8;
    localparam int         SET_MM_LSB  = 0;
    localparam int         SET_HH_LSB  = 8;

    // Both operands are valid packed BCD, so a plain binary compare orders them correctly.
    function automatic logic entry_in_range(input logic [1:0] field, input logic [7:0] value);
        logic ok;
        ok = 1'b0;
        case (field)
            FIELD_HOUR: ok = (value <= LIMIT_HOUR);
            FIELD_MIN:  ok = (value <= LIMIT_MIN);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_set_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_set_datapath_if
// Purpose  : Strobes and keypad digits from the timer-set PLA, plus the
//            committed time and status returned by the datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface timer_set_datapath_if;

    logic        key_valid;
    logic [3:0]  key_digit;
    logic        kc;
    logic        la;
    logic        lb;
    logic        er;
    logic        lr;
    logic        ea;
    logic [1:0]  s;
    logic        k7;
    logic [15:0] set_time;
    logic        set_strobe;
    logic        digit_err;

    modport master (
        output key_valid, key_digit, kc, la, lb, er, lr, ea, s,
        input  k7, set_time, set_strobe, digit_err
    );

    modport slave (
        input  key_valid, key_digit, kc, la, lb, er, lr, ea, s,
        output k7, set_time, set_strobe, digit_err
    );

endinterface
`default_nettype wire

// File: rtl/timer_set_datapath_bcd_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_buffer
// Purpose  : Two-digit BCD shift register with saturating count, sticky
//            non-BCD error and, under TIMER_SET_TIMEOUT_EN, an idle clear.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_buffer
    import timer_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       key_valid_i,
    input  wire logic [3:0] key_digit_i,
    input  wire logic       clear_i,
    input  wire logic       err_clear_i,
    output logic      [7:0] value_o,
    output logic      [1:0] count_o,
    output logic            digit_err_o
);

    logic [7:0] value_q, value_d;
    logic [1:0] count_q, count_d;
    logic       err_q,   err_d;
    logic       w_key_ok;
    logic       w_key_bad;
    logic       w_timeout;

    assign w_key_ok  = key_valid_i && (key_digit_i <= BCD_MAX);
    assign w_key_bad = key_valid_i && (key_digit_i >  BCD_MAX);

`ifdef TIMER_SET_TIMEOUT_EN
    localparam int unsigned          IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // A key arriving on the terminal cycle counts as activity, so it is kept.
    assign w_timeout = (count_q != 2'd0) && (idle_q == IDLE_LAST) && !key_valid_i;

    always_comb begin
        idle_d = idle_q + 1'b1;
        if (key_valid_i || clear_i || (count_q == 2'd0) || w_timeout) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        err_d   = err_q;
        if (clear_i || w_timeout) begin
            value_d = 8'h00;
            count_d = 2'd0;
        end else if (w_key_ok) begin
            value_d = {value_q[3:0], key_digit_i};
            if (count_q != 2'd2) begin
                count_d = count_q + 2'd1;
            end
        end
        // A clear in the same cycle drops the key, including its error flag.
        if (err_clear_i) begin
            err_d = 1'b0;
        end else if (w_key_bad && !clear_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 8'h00;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign value_o     = value_q;
    assign count_o     = count_q;
    assign digit_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/timer_set_datapath.sv
`default_nettype none
// ============================================================================
// Module   : timer_set_datapath
// Purpose  : Hour/minute entry registers, limit check (k7) and committed
//            set_time with one-cycle set_strobe. Option: TIMER_SET_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timer_set_datapath
    import timer_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input wire logic             clk,
    input wire logic             rst,
    timer_set_datapath_if.slave  bus
);

    logic [7:0]  w_value;
    logic [1:0]  w_count;
    logic        w_digit_err;

    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] r_q, r_d;
    logic        strobe_q, strobe_d;

    bcd_digit_buffer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .key_valid_i (bus.key_valid),
        .key_digit_i (bus.key_digit),
        .clear_i     (bus.kc | bus.er),
        .err_clear_i (bus.kc),
        .value_o     (w_value),
        .count_o     (w_count),
        .digit_err_o (w_digit_err)
    );

    // Latches read the registered buffer, so a same-cycle er still delivers the old digits,
    // and lr with la/lb commits the previous A/B.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        strobe_d = bus.ea;
        if (bus.la) begin
            a_d = w_value;
        end
        if (bus.lb) begin
            b_d = w_value;
        end
        if (bus.lr) begin
            r_d[SET_HH_LSB +: SET_FIELD_W] = a_q;
            r_d[SET_MM_LSB +: SET_FIELD_W] = b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            r_q      <= 16'h0000;
            strobe_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.k7         = (w_count == 2'd2) && entry_in_range(bus.s, w_value);
    assign bus.set_time   = r_q;
    assign bus.set_strobe = strobe_q;
    assign bus.digit_err  = w_digit_err;

endmodule
`default_nettype wire
